// File: rtl/data_read_capture_ctrl.sv
// Capture controller: after a start request, it streams NUM_BANKS*BANK_DEPTH qualified samples into a banked buffer.
// Optional feature macro: DATA_READ_TRIG_EN. When it is defined, ARM waits for the external trig input to go high.
module data_read_capture_ctrl #(
  parameter int BANK_DEPTH = 1024,
  parameter int NUM_BANKS  = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          cr_start,
  input  logic                          cr_abort,
  input  logic                          trig,
  input  logic                          sample_valid,
  input  logic [31:0]                   sample_data,
  output logic                          buf_we,
  output logic [$clog2(BANK_DEPTH)-1:0] buf_waddr,
  output logic [$clog2(NUM_BANKS)-1:0]  buf_wsel,
  output logic [31:0]                   buf_wdata,
  output logic                          sr_c,
  output logic                          busy,
  output logic                          sr_ovr
);

  localparam int AW = $clog2(BANK_DEPTH);
  localparam int SW = $clog2(NUM_BANKS);
  localparam int CW = AW + SW;
  localparam logic [CW-1:0] LAST_WORD = {CW{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [SW-1:0] r_wsel;
  logic [31:0]   r_wdata;
  logic          r_sr_c;
  logic          r_sr_ovr;
  logic          r_busy;
  logic          w_arm_go;

`ifdef DATA_READ_TRIG_EN
  assign w_arm_go = trig;
`else
  // The trig port is kept for a uniform interface, but ARM always lasts a single cycle.
  assign w_arm_go = 1'b1 | trig;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wsel   <= '0;
      r_wdata  <= '0;
      r_sr_c   <= 1'b0;
      r_sr_ovr <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      // NOTE: buf_we defaults low each cycle. The address and data registers are left unassigned, so they hold.
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cr_start) begin
            r_state  <= S_ARM;
            r_cnt    <= '0;
            r_sr_c   <= 1'b0;
            r_sr_ovr <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        S_ARM: begin
          if (cr_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_arm_go) begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (cr_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (sample_valid) begin
            r_we    <= 1'b1;
            r_waddr <= r_cnt[AW-1:0];
            r_wsel  <= r_cnt[CW-1:AW];
            r_wdata <= sample_data;
            if (r_cnt == LAST_WORD) begin
              // The counter parks on the final word; sr_c rises together with the last buf_we.
              r_state <= S_DONE;
              r_sr_c  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (cr_start) begin
            r_state  <= S_ARM;
            r_cnt    <= '0;
            r_sr_c   <= 1'b0;
            r_sr_ovr <= 1'b0;
            r_busy   <= 1'b1;
          end else if (sample_valid) begin
            r_sr_ovr <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign buf_we    = r_we;
  assign buf_waddr = r_waddr;
  assign buf_wsel  = r_wsel;
  assign buf_wdata = r_wdata;
  assign sr_c      = r_sr_c;
  assign sr_ovr    = r_sr_ovr;
  assign busy      = r_busy;

endmodule

// File: doc/data_read_capture_ctrl.md
DATA_READ_CAPTURE_CTRL -- requirements
Module: data_read_capture_ctrl

Interface
REQ-001 Parameter: BANK_DEPTH, 1024, words per bank; fixed power of two, sets 10-bit bank address.
REQ-002 Parameter: NUM_BANKS, 4, banks filled per capture; sets 2-bit bank select.
REQ-003 S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 S_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-005 cr_start  in  1  one-cycle pulse from CR write; requests a new capture.
REQ-006 cr_abort  in  1  one-cycle pulse; aborts capture in progress.
REQ-007 trig  in  1  external capture trigger, level; used only when DATA_READ_TRIG_EN is defined.
REQ-008 sample_valid  in  1  qualifies sample_data this cycle; no backpressure.
REQ-009 sample_data  in  32  sample word.
REQ-010 buf_we  out  1  buffer write enable.
REQ-011 buf_waddr  out  10  word address within selected bank.
REQ-012 buf_wsel  out  2  bank select for write.
REQ-013 buf_wdata  out  32  write data.
REQ-014 sr_c  out  1  SR.C: capture complete, all banks filled.
REQ-015 busy  out  1  high in ARM or CAPTURE.
REQ-016 sr_ovr  out  1  sticky: sample_valid seen in DONE before a new cr_start.

Function
REQ-017 FSM states: IDLE, ARM, CAPTURE, DONE.
REQ-018 IDLE -> ARM on cr_start; DONE -> ARM on cr_start.
REQ-019 ARM -> CAPTURE on next cycle if DATA_READ_TRIG_EN undefined, else on first cycle trig=1 while in ARM.
REQ-020 CAPTURE -> DONE on the cycle the last word (bank NUM_BANKS-1, address BANK_DEPTH-1) is accepted.
REQ-021 ARM or CAPTURE -> IDLE on cr_abort; cr_abort takes priority over trig, sample_valid and cr_start in that cycle.
REQ-022 cr_start in ARM or CAPTURE shall be ignored (no restart, counters unchanged).
REQ-023 Entry to ARM shall clear write counter to 0, sr_c to 0 and sr_ovr to 0.
REQ-024 In CAPTURE each cycle with sample_valid=1 shall accept one word; samples in IDLE, ARM, DONE not written.
REQ-025 Accepted word shall appear registered one cycle later: buf_we=1, buf_wdata=sample_data, buf_waddr/buf_wsel = counter value at acceptance.
REQ-026 Write counter is 12 bits {bank, addr}; increments by 1 per accepted word; addr wraps 1023->0 with bank+1.
REQ-027 Counter shall not wrap past 4095; DONE holds counter at final value.
REQ-028 buf_we shall be 0 in every cycle not following an accepted word; buf_waddr/buf_wsel/buf_wdata hold last values when buf_we=0.
REQ-029 sr_c shall rise in the cycle after the last write (same cycle as final buf_we) and stay 1 until next cr_start or reset.
REQ-030 sr_ovr shall set on sample_valid=1 in DONE; cleared only by ARM entry or reset.
REQ-031 Abort shall leave sr_c=0; partial buffer content undefined to software.

Reset
REQ-032 On S_AXI_ARESETN=0, immediately: state IDLE, counter 0, buf_we 0, buf_waddr 0, buf_wsel 0, buf_wdata 0, sr_c 0, sr_ovr 0, busy 0.
REQ-033 Reset mid-capture shall discard progress; no write after reset release until a new cr_start.

Configuration
REQ-034 Macro DATA_READ_TRIG_EN: defined -> ARM waits for trig=1 (REQ-019), trig sampled only in ARM; undefined -> trig port present but ignored, ARM lasts exactly one cycle.

Verification
REQ-035 cr_start, then 4096 consecutive sample_valid with data=index -> buf_we 4096 times, bank0 addr0 data 0 ... bank3 addr1023 data 4095; sr_c=1 with final write; busy=0 after.
REQ-036 sample_valid toggling every other cycle, addr 1023 of bank 0 -> next write bank1 addr0; total 4096 writes, no gaps in addresses.
REQ-037 cr_abort after 100 words -> IDLE next cycle, no further buf_we, sr_c=0; new cr_start restarts at bank0 addr0.
REQ-038 cr_start mid-capture at word 500 -> ignored, write 501 at addr 501; sample_valid after DONE -> sr_ovr=1, no buf_we.
REQ-039 DATA_READ_TRIG_EN defined: cr_start, trig low 20 cycles with samples -> no writes; trig high -> first write uses sample of trig cycle+1 at addr 0.
REQ-040 S_AXI_ARESETN low at word 2000 -> all outputs 0 asynchronously; after release, samples produce no writes until cr_start.
